bcd_display_driver: RTL

//  Downstream consumer of the 8-bit binary counter output. Converts the count to
//  3-digit BCD with a sequential shift-add-3 (double dabble) FSM, one iteration
//  per clock. Time-multiplexes the digits onto one common 7-segment bus with
//  per-digit anode selects. Sits between the counter and the board display pins.

---
 rtl/cnt_disp_pkg.sv | 47 ++++
 rtl/bcd_to_seg7.sv | 29 ++
 rtl/bcd_display_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cnt_disp_pkg.sv
// Shared widths, converter state type, 7-segment and anode codes for the BCD display driver.
package cnt_disp_pkg;

  localparam int unsigned VAL_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned SR_W   = BCD_W + VAL_W;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 3;
  localparam int unsigned ITER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low one-hot anodes, bit order {hund,tens,ones}
  localparam logic [AN_W-1:0] AN_ONES = 3'b110;
  localparam logic [AN_W-1:0] AN_TENS = 3'b101;
  localparam logic [AN_W-1:0] AN_HUND = 3'b011;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int d = 0; d < 3; d++) begin
      if (t[VAL_W + 4*d +: 4] >= 4'd5) begin
        t[VAL_W + 4*d +: 4] = t[VAL_W + 4*d +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; blank or non-decimal input shows nothing.
module bcd_to_seg7
  import cnt_disp_pkg::*;
(
  input  logic [3:0]       digit,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (one double-dabble step per clock) driving a
// time-multiplexed 3-digit common-segment display with leading-zero blanking.
module bcd_display_driver
  import cnt_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [VAL_W-1:0] i_value,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_bcd_vld,
  output logic             o_busy,
  output logic [SEG_W-1:0] o_seg,
  output logic [AN_W-1:0]  o_an
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VAL_W - 1);

  conv_state_e       state, state_nx;
  logic [VAL_W-1:0]  last_val, last_nx;
  logic [SR_W-1:0]   sr, sr_nx;
  logic [ITER_W-1:0] iter, iter_nx;
  logic [BCD_W-1:0]  bcd_nx;
  logic              vld_nx;
  logic              busy_nx;

  logic [CW-1:0]     rcnt, rcnt_nx;
  logic [1:0]        idx, idx_nx;
  logic [3:0]        digit;
  logic              blank;
  logic [AN_W-1:0]   an_nx;
  logic [SEG_W-1:0]  seg_c;

  // Converter next-state: sample on change, 8 shift-add-3 steps, then publish.
  always_comb begin
    state_nx = state;
    last_nx  = last_val;
    sr_nx    = sr;
    iter_nx  = iter;
    bcd_nx   = o_bcd;
    vld_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_value != last_val) begin
          last_nx  = i_value;
          sr_nx    = {{BCD_W{1'b0}}, i_value};
          iter_nx  = '0;
          state_nx = ST_CONV;
        end
      end
      ST_CONV: begin
        sr_nx   = dd_step(sr);
        iter_nx = iter + ITER_W'(1);
        if (iter == ITER_LAST) state_nx = ST_DONE;
      end
      ST_DONE: begin
        bcd_nx   = sr[SR_W-1:VAL_W];
        vld_nx   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Busy covers the whole conversion including the cycle the result appears.
    busy_nx = (state_nx != ST_IDLE) || (state == ST_DONE);
  end

  // Refresh timing and digit select; segments follow the value being registered into o_bcd.
  always_comb begin
    rcnt_nx = rcnt + CW'(1);
    idx_nx  = idx;
    if (rcnt == CW'(REFRESH_DIV - 1)) begin
      rcnt_nx = '0;
      idx_nx  = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    digit = bcd_nx[3:0];
    blank = 1'b0;
    an_nx = AN_ONES;
    case (idx_nx)
      2'd1: begin
        digit = bcd_nx[7:4];
        blank = (bcd_nx[11:8] == 4'd0) && (bcd_nx[7:4] == 4'd0);
        an_nx = AN_TENS;
      end
      2'd2: begin
        digit = bcd_nx[11:8];
        blank = (bcd_nx[11:8] == 4'd0);
        an_nx = AN_HUND;
      end
      default: begin
        digit = bcd_nx[3:0];
        blank = 1'b0;
        an_nx = AN_ONES;
      end
    endcase
  end

  bcd_to_seg7 u_seg (
    .digit (digit),
    .blank (blank),
    .seg_c (seg_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      last_val  <= '0;
      sr        <= '0;
      iter      <= '0;
      o_bcd     <= '0;
      o_bcd_vld <= 1'b0;
      o_busy    <= 1'b0;
      rcnt      <= '0;
      idx       <= '0;
      o_an      <= AN_ONES;
      o_seg     <= SEG_0;
    end else begin
      state     <= state_nx;
      last_val  <= last_nx;
      sr        <= sr_nx;
      iter      <= iter_nx;
      o_bcd     <= bcd_nx;
      o_bcd_vld <= vld_nx;
      o_busy    <= busy_nx;
      rcnt      <= rcnt_nx;
      idx       <= idx_nx;
      o_an      <= an_nx;
      o_seg     <= seg_c;
    end
  end

endmodule
